exit_status_chip_top: RTL and testbench
=======================================

# exit_status_chip_top

Test-completion monitor for the chip-top simulation harness. Software running on the core writes its result to a memory-mapped exit register over APB. The block latches that result and drives a sticky `exit_done`/`exit_status` pair that the top-level bench waits on. It also provides a free-running cycle counter, an optional watchdog timeout, and read-only registers that report the build configuration.

## Interface
Parameters:
- `SPI`, default "SINGLE": SPI boot mode; legal values "SINGLE" and "QUAD".
- `BAUDRATE`, default 781250: UART baud rate, reported in BAUD.
- `TEST`, default "": test mode; legal values "" and "DEBUG".
- `DUT_IMPL`, default "NORMAL": implementation tag; any value other than "NORMAL" counts as alternate.
- `USE_ZERO_RISCY`, default 0: selects the zero-riscy core (1) instead of riscy (0).
- `RISCY_RV32F`, default 0: FPU present on riscy.
- `ZERO_RV32M`, default 1: M extension present on zero-riscy.
- `ZERO_RV32E`, default 0: zero-riscy uses the E base ISA.
- `TIMEOUT_CYCLES`, default 0: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `s_clk` in 1: the single clock; all logic samples on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `paddr` in 12: APB byte address; only bits [3:2] are decoded.
- `psel`, `penable`, `pwrite` in 1 each: APB control.
- `pwdata` in 32: APB write data.
- `prdata` out 32: APB read data.
- `pready` out 1: tied to 1.
- `pslverr` out 1: error flag for the access phase.
- `exit_done` out 1: sticky flag; the test has finished.
- `exit_status` out 8: result code. 0x00 SUCCESS, 0x01 FAIL, 0xFE TIMEOUT, 0xFF ERROR.

## Operation
Register map (word offsets):
- 0x0 EXIT (RW).
  - Write, when `exit_done`=0: set `exit_done`=1 and `exit_status`=`pwdata[7:0]`.
  - Write, when `exit_done`=1: ignored, no error.
  - Read: returns {`exit_done`, 23'b0, `exit_status`}.
- 0x4 CONFIG (RO), one bit per field:
  - [0] SPI=="QUAD"
  - [1] TEST=="DEBUG"
  - [2] USE_ZERO_RISCY
  - [3] RISCY_RV32F
  - [4] ZERO_RV32M
  - [5] ZERO_RV32E
  - [6] DUT_IMPL!="NORMAL"
  - all other bits 0
- 0x8 CYCLES (RO): 32-bit cycle counter.
- 0xC BAUD (RO): BAUDRATE, zero-extended to 32 bits.

Access rules:
- Writes to CONFIG, CYCLES or BAUD are ignored and assert `pslverr` in the access phase.
- Offsets with `paddr[1:0]`≠0 are ignored and assert `pslverr`; reads of them return 0.
- `prdata` is 0 whenever the block is not in a read access phase.

Cycle counter:
- Increments by 1 every cycle while `exit_done`=0.
- Saturates at 0xFFFF_FFFF.
- Freezes once `exit_done`=1.

Watchdog, only when TIMEOUT_CYCLES>0:
- Trips at the edge where the counter value equals TIMEOUT_CYCLES−1 and `exit_done`=0.
- On that edge, `exit_done`←1 and `exit_status`←0xFE.
- If an EXIT write is in its access phase on the same edge, the write wins and its data is latched instead.

Reset values:
- `exit_done`=0.
- `exit_status`=0xFF (ERROR), so a run that never reports reads as an error.
- Counter=0.
- `prdata`=0, `pslverr`=0.

Reset during a run, or after `exit_done` is set, clears all state to the reset values.

## Timing
- APB write commits on the rising edge where `psel`&`penable`&`pwrite`=1. `exit_done`/`exit_status` change on that edge and are visible the following cycle.
- Zero wait states. `prdata` and `pslverr` are combinational during the access phase.
- A setup phase alone (`psel`=1, `penable`=0) has no effect.
- CYCLES reads the registered counter value: the number of completed cycles since reset deassertion, minus nothing.
- `exit_done`, once set, holds until `rst`. Bit 31 of a read of EXIT always matches `exit_done`.
- `rst` is sampled on `s_clk`. Asserting it for one cycle is sufficient.

## Test plan
- Reset, then idle 10 cycles: `exit_done`=0, `exit_status`=0xFF, CYCLES read=10±1 depending on read edge, BAUD=781250, CONFIG=0x10 with default parameters.
- Write EXIT=0x00: the next cycle gives `exit_done`=1, `exit_status`=0x00. A following write of 0x01 is ignored, status stays 0x00, and CYCLES stops advancing.
- Write EXIT=0x01, then assert `rst` for 1 cycle: `exit_done`=0, `exit_status`=0xFF, counter restarts from 0.
- TIMEOUT_CYCLES=20 with no write: `exit_done` rises after edge 20 with `exit_status`=0xFE. Repeat with the EXIT write (0x00) on that same edge: status=0x00.
- Write to 0x8, then read 0x6: `pslverr`=1 in both access phases, `prdata`=0 on the 0x6 read, no state change.
- Parameters SPI="QUAD", TEST="DEBUG", USE_ZERO_RISCY=1: CONFIG reads 0x17.

Source files
------------

// File: rtl/exit_status_chip_top.sv
// Test-completion monitor: latches the software exit code written over APB,
// runs a saturating cycle counter with an optional watchdog, and reports build config.
module exit_status_chip_top #(
  parameter string       SPI            = "SINGLE",
  parameter int unsigned BAUDRATE       = 781250,
  parameter string       TEST           = "",
  parameter string       DUT_IMPL       = "NORMAL",
  parameter bit          USE_ZERO_RISCY = 1'b0,
  parameter bit          RISCY_RV32F    = 1'b0,
  parameter bit          ZERO_RV32M     = 1'b1,
  parameter bit          ZERO_RV32E     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        s_clk,
  input  logic        rst,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        exit_done,
  output logic [7:0]  exit_status
);

  typedef enum logic [1:0] {
    REG_EXIT   = 2'd0,
    REG_CONFIG = 2'd1,
    REG_CYCLES = 2'd2,
    REG_BAUD   = 2'd3
  } reg_sel_e;

  localparam logic [7:0] STATUS_TIMEOUT = 8'hFE;
  localparam logic [7:0] STATUS_ERROR   = 8'hFF;

  localparam logic [31:0] CONFIG_VAL = {25'd0,
                                        DUT_IMPL != "NORMAL",
                                        ZERO_RV32E,
                                        ZERO_RV32M,
                                        RISCY_RV32F,
                                        USE_ZERO_RISCY,
                                        TEST == "DEBUG",
                                        SPI == "QUAD"};

  localparam logic [31:0] BAUD_VAL = 32'(BAUDRATE);
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST  = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [31:0] cycles;
  reg_sel_e    sel;
  logic        access;
  logic        aligned;
  logic        exit_wr;
  logic        wd_trip;

  assign sel     = reg_sel_e'(paddr[3:2]);
  assign access  = psel & penable;
  assign aligned = (paddr[1:0] == 2'b00);
  assign pready  = 1'b1;

  // Only EXIT is writable; misaligned offsets fault for both reads and writes.
  assign pslverr = access & (~aligned | (pwrite & (sel != REG_EXIT)));
  assign exit_wr = access & pwrite & aligned & (sel == REG_EXIT) & ~exit_done;
  assign wd_trip = WD_EN & ~exit_done & (cycles == WD_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prdata = 32'd0;
    if (access && !pwrite && aligned) begin
      unique case (sel)
        REG_EXIT:   prdata = {exit_done, 23'd0, exit_status};
        REG_CONFIG: prdata = CONFIG_VAL;
        REG_CYCLES: prdata = cycles;
        REG_BAUD:   prdata = BAUD_VAL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      cycles      <= 32'd0;
      exit_done   <= 1'b0;
      exit_status <= STATUS_ERROR;
    end else begin
      if (!exit_done && cycles != 32'hFFFF_FFFF) begin
        cycles <= cycles + 32'd1;
      end
      // A software exit on the watchdog edge takes precedence over the timeout.
      if (exit_wr) begin
        exit_done   <= 1'b1;
        exit_status <= pwdata[7:0];
      end else if (wd_trip) begin
        exit_done   <= 1'b1;
        exit_status <= STATUS_TIMEOUT;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{paddr[11:4], pwdata[31:8]};

endmodule

// File: tb/tb_exit_status_chip_top.sv
// Directed bench for exit_status_chip_top: default, watchdog and alternate-config
// instances share one APB bus with per-instance select and reset.
module tb_exit_status_chip_top;

  logic        s_clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata      [3];
  logic        pready      [3];
  logic        pslverr     [3];
  logic        exit_done   [3];
  logic [7:0]  exit_status [3];

  logic [31:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;

  // Reference cycle count and done flag for the default instance.
  logic [31:0] m_cyc;
  logic        m_done;

  always #5 s_clk = ~s_clk;

  exit_status_chip_top u_dflt (
    .s_clk(s_clk), .rst(rst[0]), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .exit_done(exit_done[0]), .exit_status(exit_status[0])
  );

  exit_status_chip_top #(.TIMEOUT_CYCLES(20)) u_wd (
    .s_clk(s_clk), .rst(rst[1]), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .exit_done(exit_done[1]), .exit_status(exit_status[1])
  );

  exit_status_chip_top #(.SPI("QUAD"), .TEST("DEBUG"), .USE_ZERO_RISCY(1'b1)) u_cfg (
    .s_clk(s_clk), .rst(rst[2]), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
    .pslverr(pslverr[2]), .exit_done(exit_done[2]), .exit_status(exit_status[2])
  );

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] expd;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, obs);
    end else begin
      expd = exp_q.pop_front();
      assert (obs === expd) passes++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expd);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge s_clk);
    #1;
    if (!m_done && m_cyc != 32'hFFFF_FFFF) m_cyc++;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    if (d == 0) begin
      m_cyc  = 32'd0;
      m_done = 1'b0;
    end
  endtask

  task automatic check_exit(input int d, input logic done, input logic [7:0] stat,
                            input string tag);
    exp_q.push_back({31'd0, done});
    check({tag, "_done"}, {31'd0, exit_done[d]});
    exp_q.push_back({24'd0, stat});
    check({tag, "_status"}, {24'd0, exit_status[d]});
  endtask

  // use_model: expected data is the reference cycle count at the access phase.
  task automatic apb_read(input int d, input logic [11:0] addr, input logic [31:0] expd,
                          input bit use_model, input logic exp_err, input string tag);
    paddr = addr; pwrite = 1'b0; psel[d] = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    exp_q.push_back(use_model ? m_cyc : expd);
    exp_q.push_back({31'd0, exp_err});
    @(negedge s_clk);
    check({tag, "_rdata"}, prdata[d]);
    check({tag, "_rerr"}, {31'd0, pslverr[d]});
    tick();
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input int d, input logic [11:0] addr, input logic [31:0] data,
                           input logic exp_err, input string tag);
    paddr = addr; pwrite = 1'b1; pwdata = data; psel[d] = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    exp_q.push_back({31'd0, exp_err});
    @(negedge s_clk);
    check({tag, "_werr"}, {31'd0, pslverr[d]});
    tick();
    if (d == 0 && !exp_err && addr[3:0] == 4'h0) m_done = 1'b1;
    psel[d] = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] frozen;
    rst = 3'b111; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0;
    m_cyc = 32'd0; m_done = 1'b0;
    tick();
    rst = 3'b000;
    m_cyc = 32'd0; m_done = 1'b0;

    // Reset state and idle outputs
    check_exit(0, 1'b0, 8'hFF, "reset");
    exp_q.push_back(32'd0);
    check("idle_prdata", prdata[0]);
    exp_q.push_back(32'd1);
    check("pready", {31'd0, pready[0]});

    // Idle 10 cycles, then read the build registers
    repeat (10) tick();
    apb_read(0, 12'h8, 32'd0, 1'b1, 1'b0, "cycles_idle");
    apb_read(0, 12'hC, 32'd781250, 1'b0, 1'b0, "baud");
    apb_read(0, 12'h4, 32'h0000_0010, 1'b0, 1'b0, "config_dflt");
    apb_read(0, 12'h0, 32'h0000_00FF, 1'b0, 1'b0, "exit_rd_pre");
    apb_read(2, 12'h4, 32'h0000_0017, 1'b0, 1'b0, "config_alt");

    // Setup phase alone has no effect
    paddr = 12'h0; pwrite = 1'b1; pwdata = 32'h0000_0001; psel[0] = 1'b1;
    tick();
    psel[0] = 1'b0; pwrite = 1'b0;
    check_exit(0, 1'b0, 8'hFF, "setup_only");

    // Exit with SUCCESS; later writes are ignored and the counter freezes
    apb_write(0, 12'h0, 32'h0000_0000, 1'b0, "exit_ok");
    check_exit(0, 1'b1, 8'h00, "exit_ok");
    apb_write(0, 12'h0, 32'h0000_0001, 1'b0, "exit_again");
    check_exit(0, 1'b1, 8'h00, "exit_again");
    frozen = m_cyc;
    apb_read(0, 12'h8, frozen, 1'b0, 1'b0, "cycles_frozen1");
    repeat (5) tick();
    apb_read(0, 12'h8, frozen, 1'b0, 1'b0, "cycles_frozen2");
    apb_read(0, 12'h0, 32'h8000_0000, 1'b0, 1'b0, "exit_rd_post");

    // Bad write target and misaligned read
    apb_write(0, 12'h8, 32'h1234_5678, 1'b1, "wr_cycles");
    apb_read(0, 12'h6, 32'd0, 1'b0, 1'b1, "rd_misaligned");
    apb_read(0, 12'h8, frozen, 1'b0, 1'b0, "cycles_after_err");
    check_exit(0, 1'b1, 8'h00, "after_err");

    // Reset clears a finished run; counter restarts from zero
    do_reset(0);
    check_exit(0, 1'b0, 8'hFF, "rst_after_done");
    apb_read(0, 12'h8, 32'd1, 1'b0, 1'b0, "cycles_restart");
    apb_write(0, 12'h0, 32'h0000_0001, 1'b0, "exit_fail");
    check_exit(0, 1'b1, 8'h01, "exit_fail");
    do_reset(0);
    check_exit(0, 1'b0, 8'hFF, "rst_after_fail");

    // Watchdog: idle through edge 19, trips on edge 20
    do_reset(1);
    repeat (19) tick();
    check_exit(1, 1'b0, 8'hFF, "wd_edge19");
    tick();
    check_exit(1, 1'b1, 8'hFE, "wd_trip");
    apb_read(1, 12'h0, 32'h8000_00FE, 1'b0, 1'b0, "wd_exit_rd");

    // Watchdog edge collides with an EXIT write; the write wins
    do_reset(1);
    repeat (18) tick();
    apb_write(1, 12'h0, 32'h0000_0000, 1'b0, "wd_race");
    check_exit(1, 1'b1, 8'h00, "wd_race");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
